// File: rtl/gbt_tx_phalgnr_pkg.sv
// Shared definitions for the TX frame-clock phase-aligner DPS controller.
//   - dps_state_t : controller state encoding
//   - DPS_UP / DPS_DOWN : values driven on the PLL updn pin
//   - DEFAULT_STEPS_PER_PERIOD : DPS steps per 40 MHz outclk period
//     (18 VCO periods x 8 steps)
//   - cnt_width() : bit width needed for a counter that runs 0..max_val-1
package gbt_tx_phalgnr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETUP     = 3'd1,
        ST_PULSE     = 3'd2,
        ST_WAIT_LOW  = 3'd3,
        ST_WAIT_HIGH = 3'd4,
        ST_GAP       = 3'd5,
        ST_DONE      = 3'd6
    } dps_state_t;

    localparam logic DPS_UP   = 1'b1;
    localparam logic DPS_DOWN = 1'b0;

    localparam int DEFAULT_STEPS_PER_PERIOD = 144;

    function automatic int cnt_width(input int max_val);
        return (max_val > 1) ? $clog2(max_val) : 1;
    endfunction

endpackage

// File: rtl/gbt_tx_phalgnr_phase_pos_ctr.sv
// Modulo-STEPS_PER_PERIOD up/down counter tracking the current outclk phase
// offset in DPS steps.
// Ports:
//   scanclk : clock
//   rst     : synchronous active-high reset (pos -> 0)
//   inc     : advance one step, STEPS_PER_PERIOD-1 wraps to 0
//   dec     : retreat one step, 0 wraps to STEPS_PER_PERIOD-1
//   clr     : force pos to 0; wins over inc/dec
//   pos     : registered position, 0..STEPS_PER_PERIOD-1
module gbt_tx_phalgnr_phase_pos_ctr
    import gbt_tx_phalgnr_pkg::*;
#(
    parameter int STEPS_PER_PERIOD = DEFAULT_STEPS_PER_PERIOD,
    parameter int POS_W            = 8
) (
    input  logic             scanclk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [POS_W-1:0] pos
);

    localparam logic [POS_W-1:0] POS_MAX = POS_W'(STEPS_PER_PERIOD - 1);

    logic [POS_W-1:0] pos_reg;
    logic [POS_W-1:0] pos_next;

    always_comb begin
        pos_next = pos_reg;
        if (clr) begin
            pos_next = '0;
        end else if (inc) begin
            pos_next = (pos_reg == POS_MAX) ? '0 : pos_reg + 1'b1;
        end else if (dec) begin
            pos_next = (pos_reg == '0) ? POS_MAX : pos_reg - 1'b1;
        end
    end

    always_ff @(posedge scanclk) begin
        if (rst) begin
            pos_reg <= '0;
        end else begin
            pos_reg <= pos_next;
        end
    end

    assign pos = pos_reg;

endmodule

// File: rtl/gbt_tx_frameclk_phalgnr_dps_ctrl.sv
// Dynamic-phase-shift initiator for the TX frame-clock phase-aligner PLL.
// Takes a request for N steps in one direction on one PLL counter and walks
// the PLL phase_en/updn/cntsel handshake one step at a time, waiting for the
// phase_done low/high response of each step. Keeps a modulo phase position.
// Ports:
//   scanclk    : sole clock (PLL scanclk); phase_done is synchronous to it
//   rst        : synchronous active-high reset
//   req_valid  : request strobe, accepted when req_ready is high
//   req_ready  : high only while idle
//   req_steps  : number of steps (0 completes immediately)
//   req_dir    : 1 = up, 0 = down
//   req_cntsel : PLL counter select
//   locked     : PLL lock; loss aborts a run and zeroes phase_pos
//   phase_done : PLL step handshake, low while a step is in progress
//   phase_en   : PLL step enable, high PHASE_EN_CYCLES cycles per step
//   updn       : PLL direction
//   cntsel     : PLL counter select
//   busy       : high whenever not idle
//   done       : one-cycle pulse on normal completion
//   error      : sticky; set on timeout, lock loss or unlocked request,
//                cleared by the next accepted locked request
//   phase_pos  : accumulated step position, 0..STEPS_PER_PERIOD-1
module gbt_tx_frameclk_phalgnr_dps_ctrl
    import gbt_tx_phalgnr_pkg::*;
#(
    parameter int STEPS_PER_PERIOD = DEFAULT_STEPS_PER_PERIOD,
    parameter int STEP_W           = 8,
    parameter int POS_W            = 8,
    parameter int PHASE_EN_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES   = 1023
) (
    input  logic              scanclk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [STEP_W-1:0] req_steps,
    input  logic              req_dir,
    input  logic [4:0]        req_cntsel,
    input  logic              locked,
    input  logic              phase_done,
    output logic              phase_en,
    output logic              updn,
    output logic [4:0]        cntsel,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [POS_W-1:0]  phase_pos
);

    localparam int PEN_W = cnt_width(PHASE_EN_CYCLES);
    localparam int TMO_W = cnt_width(TIMEOUT_CYCLES);
    localparam logic [PEN_W-1:0] PEN_LAST = PEN_W'(PHASE_EN_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    dps_state_t        state_reg, state_next;
    logic [STEP_W-1:0] remaining_reg, remaining_next;
    logic              dir_reg, dir_next;
    logic [4:0]        cntsel_lat_reg, cntsel_lat_next;
    logic [PEN_W-1:0]  pulse_cnt_reg, pulse_cnt_next;
    logic [TMO_W-1:0]  tmo_cnt_reg, tmo_cnt_next;
    logic              error_reg, error_next;

    logic              phase_en_reg;
    logic              updn_reg;
    logic [4:0]        cntsel_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              req_ready_reg;

    logic              step_done;
    logic              pos_inc;
    logic              pos_dec;
    logic              pos_clr;

    // Next-state and bookkeeping.
    always_comb begin
        state_next      = state_reg;
        remaining_next  = remaining_reg;
        dir_next        = dir_reg;
        cntsel_lat_next = cntsel_lat_reg;
        pulse_cnt_next  = pulse_cnt_reg;
        tmo_cnt_next    = tmo_cnt_reg + 1'b1;
        error_next      = error_reg;
        step_done       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                tmo_cnt_next = '0;
                if (req_valid) begin
                    dir_next        = req_dir;
                    cntsel_lat_next = req_cntsel;
                    remaining_next  = req_steps;
                    if (!locked) begin
                        // Accepted but refused: flag it and stay idle.
                        error_next = 1'b1;
                    end else begin
                        error_next = 1'b0;
                        state_next = (req_steps == '0) ? ST_DONE : ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                pulse_cnt_next = '0;
                state_next     = ST_PULSE;
            end
            ST_PULSE: begin
                pulse_cnt_next = pulse_cnt_reg + 1'b1;
                if (pulse_cnt_reg == PEN_LAST) begin
                    tmo_cnt_next = '0;
                    state_next   = ST_WAIT_LOW;
                end
            end
            ST_WAIT_LOW: begin
                if (!phase_done) begin
                    tmo_cnt_next = '0;
                    state_next   = ST_WAIT_HIGH;
                end else if (tmo_cnt_reg == TMO_LAST) begin
                    error_next = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_WAIT_HIGH: begin
                if (phase_done) begin
                    step_done      = 1'b1;
                    remaining_next = remaining_reg - 1'b1;
                    state_next     = (remaining_reg == STEP_W'(1)) ? ST_DONE : ST_GAP;
                end else if (tmo_cnt_reg == TMO_LAST) begin
                    // Unfinished step: position is not advanced.
                    error_next = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_GAP: begin
                state_next = ST_SETUP;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Lock loss overrides everything: the PLL relocks at zero phase.
        if (!locked && (state_reg != ST_IDLE)) begin
            state_next = ST_IDLE;
            error_next = 1'b1;
            step_done  = 1'b0;
        end
    end

    assign pos_inc = step_done && (dir_reg == DPS_UP);
    assign pos_dec = step_done && (dir_reg == DPS_DOWN);
    assign pos_clr = !locked;

    always_ff @(posedge scanclk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            remaining_reg  <= '0;
            dir_reg        <= 1'b0;
            cntsel_lat_reg <= '0;
            pulse_cnt_reg  <= '0;
            tmo_cnt_reg    <= '0;
            error_reg      <= 1'b0;
            phase_en_reg   <= 1'b0;
            updn_reg       <= 1'b0;
            cntsel_reg     <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            req_ready_reg  <= 1'b1;
        end else begin
            state_reg      <= state_next;
            remaining_reg  <= remaining_next;
            dir_reg        <= dir_next;
            cntsel_lat_reg <= cntsel_lat_next;
            pulse_cnt_reg  <= pulse_cnt_next;
            tmo_cnt_reg    <= tmo_cnt_next;
            error_reg      <= error_next;
            // Outputs are registered from the next state so they line up
            // with the state they describe.
            phase_en_reg   <= (state_next == ST_PULSE);
            busy_reg       <= (state_next != ST_IDLE);
            req_ready_reg  <= (state_next == ST_IDLE);
            // done is the registered image of the DONE cycle, so it appears
            // as the controller returns to idle.
            done_reg       <= (state_reg == ST_DONE) && locked;
            // updn/cntsel are loaded on entry to SETUP and then held.
            if (state_next == ST_SETUP) begin
                updn_reg   <= dir_next;
                cntsel_reg <= cntsel_lat_next;
            end
        end
    end

    gbt_tx_phalgnr_phase_pos_ctr #(
        .STEPS_PER_PERIOD (STEPS_PER_PERIOD),
        .POS_W            (POS_W)
    ) u_phase_pos_ctr (
        .scanclk (scanclk),
        .rst     (rst),
        .inc     (pos_inc),
        .dec     (pos_dec),
        .clr     (pos_clr),
        .pos     (phase_pos)
    );

    assign req_ready = req_ready_reg;
    assign phase_en  = phase_en_reg;
    assign updn      = updn_reg;
    assign cntsel    = cntsel_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign error     = error_reg;

endmodule

// File: tb/tb_gbt_tx_frameclk_phalgnr_dps_ctrl.sv
module tb_gbt_tx_frameclk_phalgnr_dps_ctrl;

    localparam int STEPS = 144;

    logic       scanclk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_steps;
    logic       req_dir;
    logic [4:0] req_cntsel;
    logic       locked;
    logic       phase_done;
    logic       phase_en;
    logic       updn;
    logic [4:0] cntsel;
    logic       busy;
    logic       done;
    logic       error;
    logic [7:0] phase_pos;

    int n_cmp = 0;
    int n_bad = 0;

    bit pll_never_drop = 1'b0;
    int pll_drop = 3;
    int pll_rise = 5;

    typedef struct {
        int         steps;
        bit         dir;
        logic [4:0] cntsel;
        int         exp_pos;
        int         exp_pulses;
    } vec_t;

    vec_t vecs[8];
    vec_t sb_q[$];

    gbt_tx_frameclk_phalgnr_dps_ctrl dut (
        .scanclk    (scanclk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_steps  (req_steps),
        .req_dir    (req_dir),
        .req_cntsel (req_cntsel),
        .locked     (locked),
        .phase_done (phase_done),
        .phase_en   (phase_en),
        .updn       (updn),
        .cntsel     (cntsel),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .phase_pos  (phase_pos)
    );

    always #5 scanclk = ~scanclk;

    // PLL model: phase_done drops pll_drop cycles after a phase_en rise and
    // returns high pll_rise cycles later.
    initial begin : pll_model
        bit pe_prev;
        bit active;
        int tc;
        pe_prev = 1'b0;
        active = 1'b0;
        tc = 0;
        phase_done = 1'b1;
        forever begin
            @(negedge scanclk);
            if (rst) begin
                active = 1'b0;
                phase_done = 1'b1;
            end else begin
                if (active) begin
                    tc++;
                    if (tc == pll_drop) phase_done = 1'b0;
                    if (tc == pll_drop + pll_rise) begin
                        phase_done = 1'b1;
                        active = 1'b0;
                    end
                end
                if (phase_en && !pe_prev && !pll_never_drop) begin
                    active = 1'b1;
                    tc = 0;
                end
            end
            pe_prev = phase_en;
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int step_pos(input int p, input bit up);
        if (up) return (p == STEPS - 1) ? 0 : p + 1;
        return (p == 0) ? STEPS - 1 : p - 1;
    endfunction

    // {phase_en, updn, cntsel, busy, done, error, req_ready, phase_pos}
    function automatic int out_vec();
        return int'({phase_en, updn, cntsel, busy, done, error, req_ready, phase_pos});
    endfunction

    task automatic tick();
        @(posedge scanclk);
        #1;
    endtask

    // Drive one request, observe it to completion, compare with the
    // scoreboard entry pushed at drive time.
    task automatic run_req(input vec_t v);
        vec_t e;
        int   pulses = 0;
        int   pe_len = 0;
        int   done_cnt = 0;
        int   done_cyc = -1;
        int   p_cur;
        bit   pe_prev = 1'b0;
        bit   width_bad = 1'b0;
        bit   hold_bad = 1'b0;
        bit   finished = 1'b0;
        p_cur = int'(phase_pos);
        sb_q.push_back(v);
        req_steps = 8'(v.steps);
        req_dir = v.dir;
        req_cntsel = v.cntsel;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int c = 1; c <= 6000 && !finished; c++) begin
            if (phase_en) begin
                pe_len++;
                if (updn !== v.dir || cntsel !== v.cntsel) hold_bad = 1'b1;
            end else if (pe_prev) begin
                pulses++;
                if (pe_len != 2) width_bad = 1'b1;
                pe_len = 0;
            end
            if (int'(phase_pos) != p_cur) begin
                check("pos_step", int'(phase_pos), step_pos(p_cur, v.dir));
                p_cur = int'(phase_pos);
            end
            if (done) begin
                done_cnt++;
                done_cyc = c;
            end
            pe_prev = phase_en;
            if (!busy) finished = 1'b1;
            else tick();
        end
        check("run_finished", int'(finished), 1);
        tick();
        if (done) done_cnt++;
        e = sb_q.pop_front();
        check("pulses", pulses, e.exp_pulses);
        check("done_count", done_cnt, 1);
        check("final_pos", int'(phase_pos), e.exp_pos);
        check("error_clear", int'(error), 0);
        check("pe_width", int'(width_bad), 0);
        check("updn_cntsel_hold", int'(hold_bad), 0);
        if (e.steps == 0) check("zero_step_done_cycle", done_cyc, 2);
        $display("txn steps=%0d dir=%0d cntsel=%0d pulses=%0d pos=%0d done=%0d",
                 v.steps, v.dir, v.cntsel, pulses, phase_pos, done_cnt);
    endtask

    initial begin : main
        int  wl;
        int  rises;
        int  done_seen;
        bit  seen_pe;
        bit  fin;
        bit  found;
        bit  pe_prev;
        bit  hold_bad;
        bit  second_run;

        vecs[0] = '{steps: 1,   dir: 1'b1, cntsel: 5'd0,  exp_pos: 1,   exp_pulses: 1};
        vecs[1] = '{steps: 1,   dir: 1'b0, cntsel: 5'd3,  exp_pos: 0,   exp_pulses: 1};
        vecs[2] = '{steps: 3,   dir: 1'b0, cntsel: 5'd2,  exp_pos: 141, exp_pulses: 3};
        vecs[3] = '{steps: 3,   dir: 1'b1, cntsel: 5'd1,  exp_pos: 0,   exp_pulses: 3};
        vecs[4] = '{steps: 144, dir: 1'b1, cntsel: 5'd0,  exp_pos: 0,   exp_pulses: 144};
        vecs[5] = '{steps: 0,   dir: 1'b1, cntsel: 5'd7,  exp_pos: 0,   exp_pulses: 0};
        vecs[6] = '{steps: 5,   dir: 1'b1, cntsel: 5'd31, exp_pos: 5,   exp_pulses: 5};
        vecs[7] = '{steps: 0,   dir: 1'b0, cntsel: 5'd9,  exp_pos: 5,   exp_pulses: 0};

        rst = 1'b1;
        req_valid = 1'b0;
        req_steps = '0;
        req_dir = 1'b0;
        req_cntsel = '0;
        locked = 1'b1;
        repeat (3) @(posedge scanclk);
        #1;
        check("reset_outputs", out_vec(), 32'h100);
        rst = 1'b0;
        tick();
        check("idle_outputs", out_vec(), 32'h100);

        for (int i = 0; i < 8; i++) run_req(vecs[i]);

        // Timeout: PLL never answers; position is 5 beforehand.
        pll_never_drop = 1'b1;
        req_steps = 8'd2;
        req_dir = 1'b0;
        req_cntsel = 5'd4;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        wl = 0;
        seen_pe = 1'b0;
        fin = 1'b0;
        done_seen = 0;
        for (int c = 0; c < 1200 && !fin; c++) begin
            if (phase_en) seen_pe = 1'b1;
            else if (seen_pe && busy) wl++;
            if (done) done_seen++;
            if (!busy) fin = 1'b1;
            else tick();
        end
        check("tmo_finished", int'(fin), 1);
        check("tmo_wait_low_cycles", wl, 1023);
        check("tmo_error", int'(error), 1);
        check("tmo_pos", int'(phase_pos), 5);
        check("tmo_phase_en", int'(phase_en), 0);
        tick();
        if (done) done_seen++;
        check("tmo_no_done", done_seen, 0);
        pll_never_drop = 1'b0;
        $display("txn timeout wait_low=%0d error=%0d pos=%0d", wl, error, phase_pos);

        // Next accepted request clears the sticky error.
        run_req('{steps: 0, dir: 1'b1, cntsel: 5'd0, exp_pos: 5, exp_pulses: 0});

        // Lock loss during WAIT_HIGH of step 2 of 4, with a request held
        // while busy that must be ignored.
        req_steps = 8'd4;
        req_dir = 1'b1;
        req_cntsel = 5'd6;
        req_valid = 1'b1;
        tick();
        req_steps = 8'd1;
        req_dir = 1'b0;
        req_cntsel = 5'd0;
        rises = 0;
        pe_prev = 1'b0;
        found = 1'b0;
        hold_bad = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            if (c == 5) req_valid = 1'b0;
            if (phase_en && !pe_prev) rises++;
            if (phase_en && (updn !== 1'b1 || cntsel !== 5'd6)) hold_bad = 1'b1;
            pe_prev = phase_en;
            if (rises == 2 && !phase_en && !phase_done) found = 1'b1;
            else tick();
        end
        req_valid = 1'b0;
        check("lock_reached_step2_wait_high", int'(found), 1);
        check("lock_pos_before", int'(phase_pos), 6);
        check("lock_hold", int'(hold_bad), 0);
        locked = 1'b0;
        tick();
        check("lock_busy", int'(busy), 0);
        check("lock_error", int'(error), 1);
        check("lock_pos", int'(phase_pos), 0);
        check("lock_phase_en", int'(phase_en), 0);
        second_run = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (phase_en || busy || done) second_run = 1'b1;
        end
        check("no_second_run", int'(second_run), 0);
        locked = 1'b1;
        repeat (10) tick();
        $display("txn lock_loss pos=%0d error=%0d busy=%0d", phase_pos, error, busy);

        run_req('{steps: 0, dir: 1'b1, cntsel: 5'd0, exp_pos: 0, exp_pulses: 0});

        // Unlocked request: accepted, flagged, stays idle.
        locked = 1'b0;
        req_steps = 8'd3;
        req_dir = 1'b1;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        check("unlocked_req_error", int'(error), 1);
        check("unlocked_req_busy", int'(busy), 0);
        tick();
        check("unlocked_req_idle", int'({busy, done, phase_en, req_ready}), 1);
        locked = 1'b1;
        tick();
        $display("txn unlocked_request error=%0d busy=%0d", error, busy);

        // Reset in the middle of a run (phase_en high).
        run_req('{steps: 2, dir: 1'b1, cntsel: 5'd11, exp_pos: 2, exp_pulses: 2});
        req_steps = 8'd3;
        req_dir = 1'b1;
        req_cntsel = 5'd12;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (2) tick();
        check("midrun_phase_en", int'(phase_en), 1);
        rst = 1'b1;
        tick();
        check("midrun_reset_outputs", out_vec(), 32'h100);
        rst = 1'b0;
        repeat (15) tick();
        check("after_reset_idle", out_vec(), 32'h100);
        $display("txn midrun_reset outputs=%0h", out_vec());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gbt_tx_frameclk_phalgnr_dps_ctrl.md
Name: gbt_tx_frameclk_phalgnr_dps_ctrl

Overview:
Dynamic-phase-shift (DPS) initiator for the TX frame-clock phase-aligner PLL. It accepts a request for N phase steps in one direction on one PLL counter, and drives the PLL phase_en/updn/cntsel handshake one step at a time. For each step it waits for the PLL's phase_done response. It also keeps a modulo phase-position count so the aligner logic knows the current outclk offset.

Parameters:
STEPS_PER_PERIOD, 144, DPS steps per 40 MHz outclk period (18 VCO periods x 8 steps).
STEP_W, 8, width of req_steps.
POS_W, 8, width of phase_pos; must satisfy 2**POS_W >= STEPS_PER_PERIOD.
PHASE_EN_CYCLES, 2, number of scanclk cycles phase_en is held high per step.
TIMEOUT_CYCLES, 1023, maximum scanclk cycles to wait for each phase_done edge.

Ports:
scanclk  in  1  sole clock; the PLL scanclk.
rst  in  1  synchronous, active-high reset.
req_valid  in  1  request strobe.
req_ready  out  1  high only in IDLE; a request is accepted on req_valid & req_ready.
req_steps  in  STEP_W  number of steps, sampled on accept.
req_dir  in  1  1 = up (updn=1), 0 = down; sampled on accept.
req_cntsel  in  5  PLL counter select; sampled on accept.
locked  in  1  PLL locked.
phase_done  in  1  PLL step-complete handshake; active-low while a step is in progress.
phase_en  out  1  to PLL.
updn  out  1  to PLL.
cntsel  out  5  to PLL.
busy  out  1  high in any state other than IDLE.
done  out  1  one-cycle pulse when a request completes normally.
error  out  1  sticky; cleared on the next accepted request or on rst.
phase_pos  out  POS_W  accumulated position, 0..STEPS_PER_PERIOD-1.

Behaviour:
- Reset values: phase_en=0, updn=0, cntsel=0, busy=0, done=0, error=0, phase_pos=0, req_ready=1, state=IDLE.
- All outputs are registered. phase_done is used directly with no synchroniser, because it is scanclk-synchronous.
- IDLE: accepting a request with locked=1 latches dir, cntsel and remaining=req_steps, and clears error.
  - If req_steps=0, go to DONE.
  - Otherwise go to SETUP.
  - A request with locked=0 is accepted, sets error, and stays in IDLE; done is not pulsed.
- SETUP (1 cycle): drive updn and cntsel. They stay stable until the step leaves WAIT_HIGH.
- PULSE: phase_en=1 for exactly PHASE_EN_CYCLES cycles, then go to WAIT_LOW.
- WAIT_LOW: wait for phase_done=0.
- WAIT_HIGH: wait for phase_done=1. On that cycle:
  - update phase_pos by ±1 modulo STEPS_PER_PERIOD (up from STEPS_PER_PERIOD-1 wraps to 0; down from 0 wraps to STEPS_PER_PERIOD-1);
  - decrement remaining;
  - if remaining is then nonzero go to GAP, else go to DONE.
- GAP (1 cycle): go to SETUP, which leaves at least one idle cycle between phase_en pulses.
- DONE (1 cycle): done=1, then return to IDLE.
- Timeout: a counter resets on entry to WAIT_LOW and again on entry to WAIT_HIGH. If it reaches TIMEOUT_CYCLES, the block:
  - sets error and drives phase_en=0;
  - goes to IDLE without pulsing done;
  - leaves phase_pos unchanged for the unfinished step.
- Lock loss: locked=0 in any non-IDLE state aborts to IDLE next cycle, sets error and sets phase_pos=0, because the PLL relocks to zero phase. locked=0 while in IDLE also clears phase_pos.
- Requests are ignored while busy, since req_ready=0.
- rst mid-operation: everything returns to reset values on the next edge.
- Minimum latency per step is 1 (SETUP) + PHASE_EN_CYCLES + 2 + 1 (GAP) cycles, plus the PLL response time.

Decomposition:
- Shared package gbt_tx_phalgnr_pkg holds:
  - the state enum (IDLE, SETUP, PULSE, WAIT_LOW, WAIT_HIGH, GAP, DONE);
  - the DPS_UP/DPS_DOWN constants;
  - the default STEPS_PER_PERIOD.
- One sub-module, gbt_tx_phalgnr_phase_pos_ctr: a modulo-STEPS_PER_PERIOD up/down counter with inc, dec and clr inputs.

Test Plan:
1. req_steps=1, dir=1, cntsel=0; PLL model drops phase_done 3 cycles after phase_en and raises it 5 cycles later -> phase_en high for exactly 2 cycles, updn=1 and cntsel=0 held throughout, phase_pos 0->1, done pulses once, error=0.
2. From phase_pos=0, req_steps=3, dir=0 -> three phase_en pulses each separated by at least 1 idle cycle; phase_pos steps 143, 142, 141; done pulses once.
3. 144 up-steps from pos 0 -> phase_pos wraps back to 0; done pulses once after the 144th phase_done rise.
4. req_steps=0 -> no phase_en; done pulses 2 cycles after accept; phase_pos unchanged.
5. PLL model never drops phase_done -> after 1023 WAIT_LOW cycles, error=1, busy=0, no done pulse, phase_pos unchanged; the next accepted request clears error.
6. locked falls during WAIT_HIGH of step 2 of 4 -> next cycle busy=0, error=1, phase_pos=0, phase_en=0. A req_valid asserted while busy during this test is ignored: no second run starts.
